// File: rtl/rca_cfg_encoder.sv
// RCA configuration encoder: queues config commands and expands each into a
// burst of RCA custom-opcode instruction words with a valid/ready output.
module rca_cfg_encoder #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_type,
    input  logic [2:0]               cmd_rca_id,
    input  logic [4:0]               cmd_rs1,
    input  logic [4:0]               cmd_rs2,
    input  logic [4:0]               cmd_rd,
    input  logic [3:0]               cmd_count,
    output logic                     inst_valid,
    input  logic                     inst_ready,
    output logic [31:0]              inst,
    output logic                     cmd_err,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [6:0]  OPCODE = 7'b0101011;
    localparam logic [2:0]  ILLEGAL_TYPE = 3'd7;

    typedef struct packed {
        logic [2:0] kind;
        logic [2:0] rca_id;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [3:0] count;
    } cmd_t;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    function automatic logic [31:0] encode(input cmd_t c);
        return {4'b0000, c.kind, c.rs2, c.rs1, c.rca_id, c.rd, OPCODE};
    endfunction

    cmd_t            r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [31:0]     r_inst;
    logic [3:0]      r_beat_cnt;
    logic            r_cmd_err;
    state_t          r_state;
    state_t          w_state_nxt;

    logic            w_full;
    logic            w_empty;
    logic            w_hs;
    logic            w_illegal;
    logic            w_push;
    logic            w_pop;
    logic            w_step;
    cmd_t            w_cmd;
    cmd_t            w_head;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_hs      = cmd_valid && !w_full;
    assign w_illegal = (cmd_type == ILLEGAL_TYPE);
    assign w_push    = w_hs && !w_illegal && !flush;
    assign w_head    = r_mem[r_rd_ptr];

    assign w_cmd = '{kind:   cmd_type,
                     rca_id: cmd_rca_id,
                     rs1:    cmd_rs1,
                     rs2:    cmd_rs2,
                     rd:     cmd_rd,
                     count:  cmd_count};

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: if (!w_empty) w_state_nxt = EMIT;
                EMIT: if (inst_ready && r_beat_cnt == 4'd0 && w_empty) w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // FSM controls: pop loads a new command, step advances the burst
    always_comb begin
        w_pop  = 1'b0;
        w_step = 1'b0;
        if (!flush) begin
            case (r_state)
                IDLE: w_pop = !w_empty;
                EMIT: begin
                    if (inst_ready) begin
                        if (r_beat_cnt != 4'd0) w_step = 1'b1;
                        else                    w_pop  = !w_empty;
                    end
                end
                default: begin
                    w_pop  = 1'b0;
                    w_step = 1'b0;
                end
            endcase
        end
    end

    // Queue storage carries no reset; occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_cmd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inst     <= 32'h0;
            r_beat_cnt <= 4'd0;
            r_cmd_err  <= 1'b0;
        end else begin
            r_cmd_err <= w_hs && w_illegal && !flush;
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
            // rs2 lives in inst[24:20] and wraps 31 -> 0 across a burst
            if (w_pop) begin
                r_inst     <= encode(w_head);
                r_beat_cnt <= w_head.count;
            end else if (w_step) begin
                r_inst[24:20] <= r_inst[24:20] + 5'd1;
                r_beat_cnt    <= r_beat_cnt - 4'd1;
            end
        end
    end

    assign cmd_ready  = !w_full;
    assign inst_valid = (r_state == EMIT);
    assign inst       = r_inst;
    assign cmd_err    = r_cmd_err;
    assign fifo_count = r_count;
    assign busy       = !w_empty || (r_state == EMIT);

endmodule

// File: tb/tb_rca_cfg_encoder.sv
// Directed self-checking bench for rca_cfg_encoder with hand-computed vectors.
module tb_rca_cfg_encoder;

    localparam int unsigned DEPTH = 8;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_type;
    logic [2:0]  cmd_rca_id;
    logic [4:0]  cmd_rs1;
    logic [4:0]  cmd_rs2;
    logic [4:0]  cmd_rd;
    logic [3:0]  cmd_count;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic        cmd_err;
    logic        busy;
    logic [3:0]  fifo_count;

    int n_cmp = 0;
    int n_err = 0;

    rca_cfg_encoder #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_type   (cmd_type),
        .cmd_rca_id (cmd_rca_id),
        .cmd_rs1    (cmd_rs1),
        .cmd_rs2    (cmd_rs2),
        .cmd_rd     (cmd_rd),
        .cmd_count  (cmd_count),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .cmd_err    (cmd_err),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [2:0] t, input logic [2:0] id,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [4:0] rd);
        return {4'b0000, t, rs2, rs1, id, rd, 7'b0101011};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] t, input logic [2:0] id, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic [3:0] cnt);
        cmd_valid  = 1'b1;
        cmd_type   = t;
        cmd_rca_id = id;
        cmd_rs1    = rs1;
        cmd_rs2    = rs2;
        cmd_rd     = rd;
        cmd_count  = cnt;
        tick();
        cmd_valid  = 1'b0;
    endtask

    initial begin
        logic [4:0] exp_rs2;
        rst = 1'b0; flush = 1'b0; cmd_valid = 1'b0; inst_ready = 1'b0;
        cmd_type = 3'd0; cmd_rca_id = 3'd0; cmd_rs1 = 5'd0; cmd_rs2 = 5'd0;
        cmd_rd = 5'd0; cmd_count = 4'd0;

        // reset values
        #12;
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst",       inst,            32'h0);
        chk("rst_cmd_err",    32'(cmd_err),    32'd0);
        chk("rst_busy",       32'(busy),       32'd0);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_cmd_ready",  32'(cmd_ready),  32'd1);
        #1 rst = 1'b1;
        tick();
        tick();
        chk("post_rst_idle", 32'(inst_valid), 32'd0);

        // single command, latency N+2
        inst_ready = 1'b1;
        push(3'd3, 3'd2, 5'd5, 5'd7, 5'd9, 4'd0);
        chk("single_n1_valid", 32'(inst_valid), 32'd0);
        chk("single_n1_count", 32'(fifo_count), 32'd1);
        tick();
        chk("single_n2_valid", 32'(inst_valid), 32'd1);
        chk("single_n2_inst",  inst,            32'h0672A4AB);
        tick();
        chk("single_done_valid", 32'(inst_valid), 32'd0);
        chk("single_done_busy",  32'(busy),       32'd0);

        // burst with rs2 wrap 30,31,0,1
        push(3'd4, 3'd1, 5'd2, 5'd30, 5'd3, 4'd3);
        tick();
        exp_rs2 = 5'd30;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("burst_valid_%0d", i), 32'(inst_valid), 32'd1);
            chk($sformatf("burst_inst_%0d", i),  inst, enc(3'd4, 3'd1, 5'd2, exp_rs2, 5'd3));
            exp_rs2 = exp_rs2 + 5'd1;
            tick();
        end
        chk("burst_end_valid", 32'(inst_valid), 32'd0);

        // backpressure until full: one entry moves into the working regs
        inst_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            push(3'd5, 3'd6, 5'(i), 5'd1, 5'(i + 10), 4'd0);
        end
        chk("full_cmd_ready",  32'(cmd_ready),  32'd0);
        chk("full_fifo_count", 32'(fifo_count), 32'(DEPTH));
        chk("full_valid",      32'(inst_valid), 32'd1);
        chk("hold_inst_0",     inst, enc(3'd5, 3'd6, 5'd0, 5'd1, 5'd10));
        tick();
        tick();
        chk("hold_inst_1",     inst, enc(3'd5, 3'd6, 5'd0, 5'd1, 5'd10));
        chk("hold_fifo_count", 32'(fifo_count), 32'(DEPTH));
        inst_ready = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            chk($sformatf("drain_valid_%0d", i), 32'(inst_valid), 32'd1);
            chk($sformatf("drain_inst_%0d", i),  inst, enc(3'd5, 3'd6, 5'(i), 5'd1, 5'(i + 10)));
            tick();
        end
        chk("drain_end_valid", 32'(inst_valid), 32'd0);
        chk("drain_end_busy",  32'(busy),       32'd0);

        // illegal type
        push(3'd7, 3'd0, 5'd1, 5'd2, 5'd3, 4'd0);
        chk("illegal_err_pulse", 32'(cmd_err),    32'd1);
        chk("illegal_count",     32'(fifo_count), 32'd0);
        chk("illegal_valid0",    32'(inst_valid), 32'd0);
        tick();
        chk("illegal_err_clear", 32'(cmd_err),    32'd0);
        chk("illegal_valid1",    32'(inst_valid), 32'd0);
        tick();
        chk("illegal_valid2",    32'(inst_valid), 32'd0);

        // flush mid-burst with a same-cycle push
        push(3'd0, 3'd0, 5'd4, 5'd0, 5'd8, 4'd15);
        tick();
        tick();
        tick();
        tick();
        chk("flush_pre_valid", 32'(inst_valid), 32'd1);
        chk("flush_pre_inst",  inst, enc(3'd0, 3'd0, 5'd4, 5'd3, 5'd8));
        flush = 1'b1;
        push(3'd1, 3'd1, 5'd1, 5'd1, 5'd1, 4'd0);
        flush = 1'b0;
        chk("flush_valid", 32'(inst_valid), 32'd0);
        chk("flush_count", 32'(fifo_count), 32'd0);
        chk("flush_busy",  32'(busy),       32'd0);
        tick();
        tick();
        chk("flush_lost_valid", 32'(inst_valid), 32'd0);

        // asynchronous reset mid-burst, no clock edge in between
        push(3'd2, 3'd5, 5'd6, 5'd6, 5'd6, 4'd15);
        push(3'd2, 3'd5, 5'd7, 5'd7, 5'd7, 4'd0);
        tick();
        chk("arst_pre_valid", 32'(inst_valid), 32'd1);
        chk("arst_pre_busy",  32'(busy),       32'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst_valid",      32'(inst_valid), 32'd0);
        chk("arst_inst",       inst,            32'h0);
        chk("arst_busy",       32'(busy),       32'd0);
        chk("arst_fifo_count", 32'(fifo_count), 32'd0);
        chk("arst_cmd_ready",  32'(cmd_ready),  32'd1);
        #2 rst = 1'b1;
        tick();
        tick();
        tick();
        chk("arst_idle_valid", 32'(inst_valid), 32'd0);
        chk("arst_idle_busy",  32'(busy),       32'd0);
        push(3'd6, 3'd7, 5'd31, 5'd31, 5'd31, 4'd0);
        tick();
        chk("arst_new_valid", 32'(inst_valid), 32'd1);
        chk("arst_new_inst",  inst, enc(3'd6, 3'd7, 5'd31, 5'd31, 5'd31));
        tick();
        chk("arst_new_done",  32'(inst_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rca_cfg_encoder.md
RCA_CFG_ENCODER -- requirements
Module: rca_cfg_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning the command queue depth (power of two, >=2).
REQ-002 SHALL have port clk  input  1  meaning the single clock; all state is on its rising edge.
REQ-003 SHALL have port rst  input  1  meaning the reset; reset is asynchronous and active-low.
REQ-004 SHALL have port flush  input  1  meaning a synchronous clear of the queue and the FSM.
REQ-005 SHALL have port cmd_valid  input  1  meaning a command is offered.
REQ-006 SHALL have port cmd_ready  output  1  meaning a command can be accepted.
REQ-007 SHALL have port cmd_type  input  3  meaning the config kind; it maps to fn7 = {4'b0, cmd_type}, with 0=USE_FB, 1=USE_NFB, 2=CPU_REG, 3=GRID_MUX, 4=IO_MUX, 5=RESULT_MUX, 6=IO_INP_MAP.
REQ-008 SHALL have port cmd_rca_id  input  3  meaning the target RCA, placed in fn3.
REQ-009 SHALL have ports cmd_rs1, cmd_rs2 and cmd_rd  input  5 each  meaning the register-address fields.
REQ-010 SHALL have port cmd_count  input  4  meaning a burst of cmd_count+1 instructions.
REQ-011 SHALL have port inst_valid  output  1  meaning the instruction word is valid.
REQ-012 SHALL have port inst_ready  input  1  meaning the consumer accepts the word.
REQ-013 SHALL have port inst  output  32  meaning the RCA instruction word.
REQ-014 SHALL have port cmd_err  output  1  meaning a one-cycle pulse flagging an illegal command.
REQ-015 SHALL have port busy  output  1  meaning the queue is non-empty or the FSM is in EMIT.
REQ-016 SHALL have port fifo_count  output  $clog2(DEPTH)+1  meaning the number of queued entries.

Function
REQ-017 SHALL encode inst = {fn7, rs2, rs1, fn3, rd, 7'b0101011}, i.e. the RCA opcode.
REQ-018 SHALL drive cmd_ready = !full, independent of the same-cycle pop and of inst_ready.
REQ-019 SHALL complete a command handshake on cmd_valid && cmd_ready.
REQ-020 SHALL, for a handshake with cmd_type==7, store no entry and assert cmd_err in the next cycle for exactly one cycle.
REQ-021 SHALL support a queue push and pop in the same cycle; fifo_count is then unchanged.
REQ-022 SHALL wrap the queue read and write pointers modulo DEPTH.
REQ-023 SHALL implement an FSM with states IDLE and EMIT.
REQ-024 SHALL, in IDLE with the queue non-empty, pop the head into the working registers, set beat_cnt = cmd_count and go to EMIT.
REQ-025 SHALL, in IDLE with the queue empty, stay in IDLE.
REQ-026 SHALL assert inst_valid only in EMIT, with inst driven purely from the working registers.
REQ-027 SHALL hold inst stable while inst_valid && !inst_ready.
REQ-028 SHALL, in EMIT on inst_ready with beat_cnt != 0, decrement beat_cnt and increment the working rs2 modulo 32 (31 -> 0); other fields are unchanged.
REQ-029 SHALL, in EMIT on inst_ready with beat_cnt == 0 and the queue non-empty, pop the next entry in the same cycle and stay in EMIT, giving back-to-back words with no bubble.
REQ-030 SHALL, in EMIT on inst_ready with beat_cnt == 0 and the queue empty, go to IDLE.
REQ-031 SHALL give a latency of 2 cycles from a command accepted in cycle N into an empty queue with FSM in IDLE to inst_valid in cycle N+2.
REQ-032 SHALL, on flush, empty the queue, force IDLE and deassert inst_valid in the next cycle.
REQ-033 SHALL drop a command handshaken in the same cycle as flush.
REQ-034 SHALL give flush priority over push, pop and the FSM.
REQ-035 SHALL hold fifo_count in the range 0..DEPTH.
REQ-036 SHALL allow busy to be combinational from state and the empty flag.

Reset
REQ-037 SHALL, while rst is low, asynchronously force state=IDLE, queue empty (pointers 0, fifo_count 0), inst_valid 0, inst 32'h0, cmd_err 0, busy 0 and beat_cnt 0.
REQ-038 SHALL drive cmd_ready to 1 during reset.
REQ-039 SHALL abandon any burst in progress when reset is asserted mid-burst; it is not resumed after reset release.
REQ-040 SHALL release reset on a clean clk edge without generating spurious inst_valid.

Verification
REQ-041 SHALL cover a single command: type=3, id=2, rs1=5, rs2=7, rd=9, count=0, inst_ready=1 -> exactly one inst = 32'h0672A4AB at cycle N+2, then busy=0.
REQ-042 SHALL cover a burst with rs2 wrap: type=4, rs2=30, count=3 -> four words with rs2 = 30, 31, 0, 1, and inst_valid deasserted after the fourth accept.
REQ-043 SHALL cover backpressure and full: DEPTH pushes with inst_ready=0 -> cmd_ready=0 and fifo_count=DEPTH; inst held constant; after inst_ready=1, all words emit in order with no gaps.
REQ-044 SHALL cover an illegal type: cmd_type=7 handshake -> cmd_err pulses for 1 cycle, fifo_count unchanged, no inst emitted.
REQ-045 SHALL cover flush mid-burst: count=15, flush after the 3rd accept with a push in the same cycle -> inst_valid=0 next cycle, fifo_count=0, pushed command lost.
REQ-046 SHALL cover async reset mid-burst: rst low between edges -> outputs reach reset values immediately without a clock; after release, idle until a new command.
